// File: rtl/fir_loader_pkg.sv
// -----------------------------------------------------------------------------
// fir_loader_pkg
// Shared definitions for the FIR coefficient pair loader:
//   - state_t : loader FSM states (IDLE, SETTLE, PENDING)
//   - COEF_W  : default width of one coefficient
//   - HI_LSB / LO_LSB : bit positions of b22 (upper half) and b23 (lower half)
//                       inside the 32-bit software register
// -----------------------------------------------------------------------------
package fir_loader_pkg;

    localparam int COEF_W = 16;
    localparam int HI_LSB = 16;
    localparam int LO_LSB = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PENDING = 2'd2
    } state_t;

endpackage

// File: rtl/fir_coeff_settle_cnt.sv
// -----------------------------------------------------------------------------
// fir_coeff_settle_cnt
// Counts consecutive equal samples of the software register. done is asserted
// on the SETTLE_CYCLES-th enabled cycle since the last clear.
// Ports:
//   user_clk    in  clock
//   user_rst_n  in  asynchronous active-low reset
//   clear       in  restart the count (register value changed)
//   enable      in  this cycle's sample equals the tracked value
//   done        out this sample completes the settle window
// -----------------------------------------------------------------------------
module fir_coeff_settle_cnt
    import fir_loader_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic user_clk,
    input  logic user_rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    // Wide enough to hold SETTLE_CYCLES itself, so cnt+1 never overflows.
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

    // cnt holds the number of equal samples already seen; this one is the last.
    assign done = enable && (cnt == CW'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/fir_coeff_pair_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_pair_loader
// Takes the 32-bit software coefficient register (b22 in the upper half, b23
// in the lower half), waits until it has been stable for SETTLE_CYCLES samples,
// holds it as pending and commits both taps together on the next frame_sync,
// so the FIR never sees a mixed pair or a mid-frame change.
// Ports:
//   user_clk    in   clock (FIR/fabric domain)
//   user_rst_n  in   asynchronous active-low reset
//   reg_in      in   software register value, already in user_clk domain
//   frame_sync  in   one-cycle frame boundary strobe
//   coef_hi     out  active b22 (reg_in[31:16] of the committed value)
//   coef_lo     out  active b23 (reg_in[15:0] of the committed value)
//   coef_upd    out  one-cycle pulse in the first cycle new taps are driven
//   pending     out  an accepted value is waiting for frame_sync
//   upd_count   out  commits since reset, wrapping
// -----------------------------------------------------------------------------
module fir_coeff_pair_loader
    import fir_loader_pkg::*;
#(
    parameter int COEF_W        = fir_loader_pkg::COEF_W,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                user_clk,
    input  logic                user_rst_n,
    input  logic [2*COEF_W-1:0] reg_in,
    input  logic                frame_sync,
    output logic [COEF_W-1:0]   coef_hi,
    output logic [COEF_W-1:0]   coef_lo,
    output logic                coef_upd,
    output logic                pending,
    output logic [CNT_W-1:0]    upd_count
);

    state_t state, state_next;

    logic [2*COEF_W-1:0] last_seen;
    logic [2*COEF_W-1:0] shadow;

    logic changed;
    logic load_last;
    logic cnt_clear;
    logic cnt_en;
    logic settle_done;
    logic load_shadow;
    logic commit;

    assign changed = (reg_in != last_seen);

    fir_coeff_settle_cnt #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_cnt (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .clear      (cnt_clear),
        .enable     (cnt_en),
        .done       (settle_done)
    );

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next  = state;
        load_last   = 1'b0;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;
        load_shadow = 1'b0;
        commit      = 1'b0;

        unique case (state)
            IDLE: begin
                if (changed) begin
                    load_last  = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (changed) begin
                    load_last = 1'b1;
                    cnt_clear = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    if (settle_done) begin
                        load_shadow = 1'b1;
                        state_next  = PENDING;
                    end
                end
            end
            PENDING: begin
                // A change on the frame_sync cycle still commits the old,
                // stable shadow; the new value then starts settling.
                if (frame_sync) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
                if (changed) begin
                    load_last  = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = SETTLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: last_seen and shadow are data registers but are reset anyway:
    // last_seen = 0 makes a nonzero post-reset reg_in register as a change,
    // and clearing shadow discards any value pending at reset.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            last_seen <= '0;
            shadow    <= '0;
            coef_hi   <= '0;
            coef_lo   <= '0;
            coef_upd  <= 1'b0;
            upd_count <= '0;
        end else begin
            coef_upd <= commit;
            if (load_last) begin
                last_seen <= reg_in;
            end
            if (load_shadow) begin
                shadow <= last_seen;
            end
            if (commit) begin
                coef_hi   <= shadow[HI_LSB +: COEF_W];
                coef_lo   <= shadow[LO_LSB +: COEF_W];
                upd_count <= upd_count + CNT_W'(1);
            end
        end
    end

    assign pending = (state == PENDING);

endmodule

// File: tb/tb_fir_coeff_pair_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coeff_pair_loader
// Directed bench for fir_coeff_pair_loader with SETTLE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_fir_coeff_pair_loader;

    localparam int COEF_W        = 16;
    localparam int SETTLE_CYCLES = 4;
    localparam int CNT_W         = 8;

    logic              user_clk;
    logic              user_rst_n;
    logic [31:0]       reg_in;
    logic              frame_sync;
    logic [COEF_W-1:0] coef_hi;
    logic [COEF_W-1:0] coef_lo;
    logic              coef_upd;
    logic              pending;
    logic [CNT_W-1:0]  upd_count;

    int n_cmp  = 0;
    int n_fail = 0;

    int upd_pulses = 0;
    bit mon_pend   = 1'b0;
    bit pend_seen  = 1'b0;

    fir_coeff_pair_loader #(
        .COEF_W        (COEF_W),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .reg_in     (reg_in),
        .frame_sync (frame_sync),
        .coef_hi    (coef_hi),
        .coef_lo    (coef_lo),
        .coef_upd   (coef_upd),
        .pending    (pending),
        .upd_count  (upd_count)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    // Independent pulse counter and pending watcher, sampled mid-cycle.
    always @(negedge user_clk) begin
        if (coef_upd) upd_pulses++;
        if (mon_pend && pending) pend_seen = 1'b1;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge user_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int p0;

        // ---------------- reset, idle register, periodic frame_sync ----------
        user_rst_n = 1'b0;
        reg_in     = 32'h0;
        frame_sync = 1'b0;
        tick(3);
        check("rst_coef_hi",  32'(coef_hi),   32'h0);
        check("rst_coef_lo",  32'(coef_lo),   32'h0);
        check("rst_coef_upd", 32'(coef_upd),  32'h0);
        check("rst_pending",  32'(pending),   32'h0);
        check("rst_count",    32'(upd_count), 32'h0);
        user_rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            frame_sync = (i % 8 == 7);
            tick();
        end
        frame_sync = 1'b0;
        tick();
        check("idle_coef_hi", 32'(coef_hi),   32'h0);
        check("idle_coef_lo", 32'(coef_lo),   32'h0);
        check("idle_pulses",  32'(upd_pulses), 32'h0);
        check("idle_count",   32'(upd_count), 32'h0);

        // ---------------- single value, frame_sync held high -----------------
        p0 = upd_pulses;
        reg_in     = 32'h1234_ABCD;
        frame_sync = 1'b1;
        tick(SETTLE_CYCLES + 1);
        check("t2_pending_before", 32'(pending),  32'h1);
        check("t2_upd_early",      32'(coef_upd), 32'h0);
        tick();
        check("t2_upd_at_s_plus_2", 32'(coef_upd),  32'h1);
        check("t2_coef_hi",         32'(coef_hi),   32'h1234);
        check("t2_coef_lo",         32'(coef_lo),   32'hABCD);
        check("t2_count",           32'(upd_count), 32'h1);
        tick();
        check("t2_upd_one_cycle", 32'(coef_upd), 32'h0);
        tick(5);
        frame_sync = 1'b0;
        check("t2_single_pulse", 32'(upd_pulses - p0), 32'h1);

        // ---------------- toggling faster than the settle window -------------
        p0 = upd_pulses;
        pend_seen = 1'b0;
        mon_pend  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            reg_in     = ((i / 3) % 2 == 1) ? 32'h0003_0004 : 32'h0001_0002;
            frame_sync = (i % 8 == 7);
            tick();
        end
        mon_pend   = 1'b0;
        frame_sync = 1'b0;
        check("t3_no_pending", 32'(pend_seen), 32'h0);
        reg_in = 32'h0003_0004;
        tick(6);
        check("t3_pending_hold", 32'(pending),  32'h1);
        check("t3_no_commit",    32'(coef_hi),  32'h1234);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("t3_upd",     32'(coef_upd),  32'h1);
        check("t3_coef_hi", 32'(coef_hi),   32'h0003);
        check("t3_coef_lo", 32'(coef_lo),   32'h0004);
        check("t3_count",   32'(upd_count), 32'h2);
        tick();
        check("t3_pulses", 32'(upd_pulses - p0), 32'h1);
        check("t3_idle",   32'(pending),         32'h0);

        // ---------------- change on the frame_sync cycle ---------------------
        reg_in = 32'h1111_2222;
        tick(SETTLE_CYCLES + 1);
        check("t4_pending", 32'(pending), 32'h1);
        reg_in     = 32'h3333_4444;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("t4_upd_old",     32'(coef_upd),  32'h1);
        check("t4_coef_hi_old", 32'(coef_hi),   32'h1111);
        check("t4_coef_lo_old", 32'(coef_lo),   32'h2222);
        check("t4_count_old",   32'(upd_count), 32'h3);
        check("t4_resettling",  32'(pending),   32'h0);
        tick(SETTLE_CYCLES - 1);
        check("t4_not_yet", 32'(pending), 32'h0);
        tick();
        check("t4_pending_new", 32'(pending), 32'h1);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("t4_coef_hi_new", 32'(coef_hi),   32'h3333);
        check("t4_coef_lo_new", 32'(coef_lo),   32'h4444);
        check("t4_count_new",   32'(upd_count), 32'h4);

        // ---------------- reset while pending --------------------------------
        reg_in = 32'h5555_6666;
        tick(SETTLE_CYCLES + 1);
        check("t5_pending", 32'(pending), 32'h1);
        user_rst_n = 1'b0;
        #1;
        check("t5_rst_pending", 32'(pending),   32'h0);
        check("t5_rst_coef_hi", 32'(coef_hi),   32'h0);
        check("t5_rst_coef_lo", 32'(coef_lo),   32'h0);
        check("t5_rst_count",   32'(upd_count), 32'h0);
        tick();
        user_rst_n = 1'b1;
        tick(SETTLE_CYCLES + 1);
        check("t5_reload_pending", 32'(pending), 32'h1);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("t5_upd",     32'(coef_upd),  32'h1);
        check("t5_coef_hi", 32'(coef_hi),   32'h5555);
        check("t5_coef_lo", 32'(coef_lo),   32'h6666);
        check("t5_count",   32'(upd_count), 32'h1);

        // ---------------- 256 commits, counter wrap --------------------------
        reg_in     = 32'h0;
        user_rst_n = 1'b0;
        tick();
        user_rst_n = 1'b1;
        tick();
        p0 = upd_pulses;
        for (int i = 0; i < 256; i++) begin
            reg_in = (i % 2 == 0) ? 32'hA5A5_5A5A : 32'h5A5A_A5A5;
            tick(SETTLE_CYCLES + 1);
            frame_sync = 1'b1;
            tick();
            frame_sync = 1'b0;
            if (i == 254) check("t6_count_255", 32'(upd_count), 32'hFF);
        end
        check("t6_count_wrap", 32'(upd_count), 32'h0);
        check("t6_coef_hi",    32'(coef_hi),   32'h5A5A);
        check("t6_coef_lo",    32'(coef_lo),   32'hA5A5);
        tick();
        check("t6_pulses", 32'(upd_pulses - p0), 32'd256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
